// File: rtl/decoder_38_hold_if.sv
// Index handshake between the upstream priority encoder and the 3:8 hold decoder.
// The master drives the index and valid flag, and the slave answers with ready.
interface decoder_38_hold_if #(
    parameter int IDX_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;

    modport master (
        output in_valid,
        output in_idx,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_idx,
        output in_ready
    );
endinterface

// File: rtl/decoder_38_hold.sv
// Decodes handshaked index codes to one-hot words, holds each word for HOLD_CYCLES clocks,
// and keeps a sticky mask of every index decoded since reset or the last clear.
module decoder_38_hold #(
    parameter  int IDX_W       = 3,
    parameter  int HOLD_CYCLES = 4,
    localparam int OUT_W       = 1 << IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    decoder_38_hold_if.slave  in_bus,
    input  logic              clr_mask,
    output logic [OUT_W-1:0]  y_onehot,
    output logic              y_valid,
    output logic [OUT_W-1:0]  seen_mask,
    output logic              busy
);

    localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic             xfer;
    logic [OUT_W-1:0] dec_word;

    // Gating with rst_n keeps ready low for the whole time reset is asserted
    assign in_bus.in_ready = rst_n && ((state == IDLE) || (state == HOLD && cnt == 8'd0));
    assign xfer            = in_bus.in_valid && in_bus.in_ready;
    assign dec_word        = OUT_W'(1) << in_bus.in_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            y_onehot <= '0;
            y_valid  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        y_onehot <= dec_word;
                        y_valid  <= 1'b1;
                        cnt      <= RELOAD;
                        busy     <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // The last held clock doubles as the accept slot so back-to-back words have no gap
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (xfer) begin
                        y_onehot <= dec_word;
                        cnt      <= RELOAD;
                    end else begin
                        y_onehot <= '0;
                        y_valid  <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    // A transfer in the same cycle as a clear still leaves its own bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_mask <= '0;
        end else begin
            seen_mask <= (clr_mask ? '0 : seen_mask) | (xfer ? dec_word : '0);
        end
    end

endmodule

// File: tb/tb_decoder_38_hold.sv
// Drives two decoders (hold length 4 and 1) with identical stimulus and checks both
// against a timestamp model: each accepted index owns the output for H clocks after its edge.
module tb_decoder_38_hold;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [7:0] y4, s4, y1, s1;
    logic       v4, b4, v1, b1;

    int total = 0;
    int bad   = 0;

    // Model state: edge counter, edge of last accept, last word, sticky mask
    int         e   = 0;
    int         lk4 = -1000;
    int         lk1 = -1000;
    logic [7:0] lw4 = 8'h00;
    logic [7:0] lw1 = 8'h00;
    logic [7:0] sm4 = 8'h00;
    logic [7:0] sm1 = 8'h00;
    logic       lastX4 = 1'b0;

    decoder_38_hold_if #(.IDX_W(3)) bus4 ();
    decoder_38_hold_if #(.IDX_W(3)) bus1 ();

    decoder_38_hold #(.IDX_W(3), .HOLD_CYCLES(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bus    (bus4),
        .clr_mask  (clr),
        .y_onehot  (y4),
        .y_valid   (v4),
        .seen_mask (s4),
        .busy      (b4)
    );

    decoder_38_hold #(.IDX_W(3), .HOLD_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bus    (bus1),
        .clr_mask  (clr),
        .y_onehot  (y1),
        .y_valid   (v1),
        .seen_mask (s1),
        .busy      (b1)
    );

    always #5 clk = ~clk;

    // Ready again once the final clock of the previous word's hold window is reached
    function automatic logic expReady(input int edgeNow, input int acceptEdge, input int h);
        return (edgeNow - acceptEdge) >= (h - 1);
    endfunction

    function automatic logic [7:0] expWord(input int edgeNow, input int acceptEdge, input int h,
                                           input logic [7:0] w);
        return ((edgeNow - acceptEdge) < h) ? w : 8'h00;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        logic [7:0] ew4, ew1;
        ew4 = expWord(e, lk4, 4, lw4);
        ew1 = expWord(e, lk1, 1, lw1);
        checkOutput("y4",    32'(y4), 32'(ew4));
        checkOutput("v4",    32'(v4), 32'(|ew4));
        checkOutput("busy4", 32'(b4), 32'(|ew4));
        checkOutput("seen4", 32'(s4), 32'(sm4));
        checkOutput("rdy4",  32'(bus4.in_ready), 32'(expReady(e, lk4, 4)));
        checkOutput("pop4",  32'($countones(y4) <= 1), 32'd1);
        checkOutput("y1",    32'(y1), 32'(ew1));
        checkOutput("v1",    32'(v1), 32'(|ew1));
        checkOutput("busy1", 32'(b1), 32'(|ew1));
        checkOutput("seen1", 32'(s1), 32'(sm1));
        checkOutput("rdy1",  32'(bus1.in_ready), 32'(expReady(e, lk1, 1)));
        checkOutput("pop1",  32'($countones(y1) <= 1), 32'd1);
    endtask

    // Presents one cycle of stimulus to both decoders, advances one edge, updates the model
    task automatic applyStimulus(input logic v, input logic [2:0] idx, input logic c);
        logic       x4, x1;
        logic [7:0] w;
        bus4.in_valid = v;
        bus4.in_idx   = idx;
        bus1.in_valid = v;
        bus1.in_idx   = idx;
        clr           = c;
        x4 = v && expReady(e, lk4, 4);
        x1 = v && expReady(e, lk1, 1);
        w  = 8'h01 << idx;
        @(posedge clk);
        #1;
        e++;
        if (x4) begin
            lk4 = e;
            lw4 = w;
        end
        if (x1) begin
            lk1 = e;
            lw1 = w;
        end
        sm4 = (c ? 8'h00 : sm4) | (x4 ? w : 8'h00);
        sm1 = (c ? 8'h00 : sm1) | (x1 ? w : 8'h00);
        lastX4 = x4;
        checkAll();
    endtask

    task automatic sendIdx4(input logic [2:0] idx, input logic c);
        int guard = 0;
        while (!expReady(e, lk4, 4) && guard < 20) begin
            applyStimulus(1'b0, 3'd0, 1'b0);
            guard++;
        end
        checkOutput("send_wait", 32'(guard < 20), 32'd1);
        applyStimulus(1'b1, idx, c);
    endtask

    task automatic idleSteps(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        int held;
        int notReady;
        int sweepIdx;
        int guard;

        rst_n         = 1'b0;
        clr           = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.in_idx   = 3'd0;
        bus1.in_valid = 1'b0;
        bus1.in_idx   = 3'd0;
        #2;
        checkOutput("rst_y4",   32'(y4), 32'h0);
        checkOutput("rst_rdy4", 32'(bus4.in_ready), 32'd0);
        checkOutput("rst_rdy1", 32'(bus1.in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkAll();

        // Single index 5 held for four clocks
        held     = 0;
        notReady = 0;
        applyStimulus(1'b1, 3'd5, 1'b0);
        if (y4 == 8'h20) held++;
        if (!bus4.in_ready) notReady++;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 3'd0, 1'b0);
            if (y4 == 8'h20) held++;
            if (!bus4.in_ready) notReady++;
        end
        checkOutput("t1_holdlen",  32'(held), 32'd4);
        checkOutput("t1_notready", 32'(notReady), 32'd3);
        checkOutput("t1_seen",     32'(s4), 32'h20);

        // Sweep every index, each taken on the first ready slot
        sweepIdx = 0;
        guard    = 0;
        while (sweepIdx < 8 && guard < 100) begin
            applyStimulus(1'b1, 3'(sweepIdx), guard == 0);
            if (lastX4) sweepIdx++;
            guard++;
        end
        checkOutput("t2_done", 32'(sweepIdx), 32'd8);
        idleSteps(4);
        checkOutput("t2_seen", 32'(s4), 32'hFF);

        // Hold length 1 with continuous valid
        idleSteps(2);
        applyStimulus(1'b1, 3'd3, 1'b0);
        checkOutput("t3_w0", 32'(y1), 32'h08);
        applyStimulus(1'b1, 3'd6, 1'b0);
        checkOutput("t3_w1", 32'(y1), 32'h40);
        applyStimulus(1'b1, 3'd1, 1'b0);
        checkOutput("t3_w2", 32'(y1), 32'h02);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("t3_idle", 32'(y1), 32'h00);

        // Clear coinciding with a transfer keeps the new bit
        idleSteps(4);
        sendIdx4(3'd2, 1'b1);
        sendIdx4(3'd3, 1'b0);
        checkOutput("t4_pre", 32'(s4), 32'h0C);
        sendIdx4(3'd7, 1'b1);
        checkOutput("t4_post", 32'(s4), 32'h80);

        // Asynchronous reset in the middle of a hold
        idleSteps(4);
        sendIdx4(3'd2, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("t5_pre", 32'(y4), 32'h04);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_y4",   32'(y4), 32'h0);
        checkOutput("t5_v4",   32'(v4), 32'd0);
        checkOutput("t5_b4",   32'(b4), 32'd0);
        checkOutput("t5_rdy4", 32'(bus4.in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        lk4 = -1000;
        lk1 = -1000;
        sm4 = 8'h00;
        sm1 = 8'h00;
        #1;
        checkOutput("t5_rdy_rel",  32'(bus4.in_ready), 32'd1);
        checkOutput("t5_seen_rel", 32'(s4), 32'h00);
        checkAll();

        // Random traffic against the model
        for (int k = 0; k < 10000; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          $urandom_range(0, 31) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
